circle_raster_engine: RTL and testbench

// - Parametrised midpoint-circle rasteriser: successor to the lab2 fixed 160x120 outline circle drawer.
// - Adds configurable screen/coordinate widths, outline or filled mode, per-pixel screen clipping and a vga_ready back-pressure input.
// - Sits between the top-level control FSM and the VGA adapter plot port.

---
 rtl/circle_pkg.sv | 35 +++
 rtl/octant_mapper.sv | 43 ++++
 rtl/circle_raster_engine.sv | 195 +++++++++++++++++++
 tb/tb_circle_raster_engine.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/circle_pkg.sv
// Shared types and helpers for the midpoint circle rasteriser.
package circle_pkg;

  // Engine FSM states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PLOT = 3'd1,
    SPAN = 3'd2,
    STEP = 3'd3,
    DONE = 3'd4
  } state_t;

  // How one octant is derived from the (ox, oy) first-octant offset.
  typedef struct packed {
    logic swap;   // use (oy, ox) instead of (ox, oy)
    logic neg_x;  // subtract the x offset from the centre
    logic neg_y;  // subtract the y offset from the centre
  } octant_t;

  // Octant walk order:
  // (+ox,+oy) (+oy,+ox) (-ox,+oy) (-oy,+ox) (-ox,-oy) (-oy,-ox) (+ox,-oy) (+oy,-ox)
  localparam logic [2:0] OCTANT_TAB [8] = '{
    3'b000, 3'b100, 3'b010, 3'b110, 3'b011, 3'b111, 3'b001, 3'b101
  };

  function automatic octant_t octant_f(input logic [2:0] k);
    return octant_t'(OCTANT_TAB[k]);
  endfunction

  // True when a signed pixel position lies inside a w x h screen.
  function automatic logic clip_f(input int px, input int py, input int w, input int h);
    return (px >= 0) && (px < w) && (py >= 0) && (py < h);
  endfunction

endpackage

// File: rtl/octant_mapper.sv
// Maps a first-octant offset and an octant index onto a signed screen point.
// Widths are large enough that cx +/- radius never wraps, so off-screen
// points stay off-screen instead of aliasing back onto the visible area.
module octant_mapper
  import circle_pkg::*;
#(
  parameter int X_W  = 8,
  parameter int Y_W  = 7,
  parameter int R_W  = 8,
  parameter int PX_W = 10,
  parameter int PY_W = 10
) (
  input  logic [X_W-1:0]         cx,
  input  logic [Y_W-1:0]         cy,
  input  logic signed [R_W:0]    ox,
  input  logic signed [R_W:0]    oy,
  input  logic [2:0]             k,
  output logic signed [PX_W-1:0] px,
  output logic signed [PY_W-1:0] py
);

  octant_t                oct;
  logic signed [R_W:0]    dx;
  logic signed [R_W:0]    dy;
  logic signed [PX_W-1:0] cx_s;
  logic signed [PX_W-1:0] dx_s;
  logic signed [PY_W-1:0] cy_s;
  logic signed [PY_W-1:0] dy_s;

  // Select swap/sign for octant k and form the point.
  always_comb begin
    oct  = octant_f(k);
    dx   = oct.swap ? oy : ox;
    dy   = oct.swap ? ox : oy;
    cx_s = $signed(PX_W'(cx));
    cy_s = $signed(PY_W'(cy));
    dx_s = PX_W'(dx);
    dy_s = PY_W'(dy);
    px   = oct.neg_x ? (cx_s - dx_s) : (cx_s + dx_s);
    py   = oct.neg_y ? (cy_s - dy_s) : (cy_s + dy_s);
  end

endmodule

// File: rtl/circle_raster_engine.sv
// Midpoint circle rasteriser: outline or filled disc, per-pixel screen
// clipping, and vga_ready back-pressure on the plot port.
//
// Handshake: a pixel is offered while vga_plot=1 with vga_x/vga_y/vga_colour
// held stable; it is transferred on a rising edge where vga_plot=1 and
// vga_ready=1. Clipped pixels are never offered and take exactly one cycle.
// The pixel outputs are decoded from registered walk state, so vga_plot does
// not depend combinationally on vga_ready. The FSM state is visible as the
// internal signal 'state'.
module circle_raster_engine
  import circle_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int R_W      = 8,
  parameter int COLOUR_W = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [X_W-1:0]      centre_x,
  input  logic [Y_W-1:0]      centre_y,
  input  logic [R_W-1:0]      radius,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                fill,
  output logic                done,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  input  logic                vga_ready
);

  localparam int PX_W = ((X_W > R_W) ? X_W : R_W) + 2;
  localparam int PY_W = ((Y_W > R_W) ? Y_W : R_W) + 2;

  state_t                state;
  logic [X_W-1:0]        cx_q;
  logic [Y_W-1:0]        cy_q;
  logic [COLOUR_W-1:0]   colour_q;
  logic                  fill_q;
  logic signed [R_W:0]   ox_q;
  logic signed [R_W:0]   oy_q;
  logic signed [R_W+1:0] crit_q;
  logic [2:0]            k_q;     // octant index in PLOT
  logic [1:0]            row_q;   // span row index in SPAN
  logic [R_W+1:0]        j_q;     // x offset from the left end of a span row

  logic [2:0]            k_sel;
  logic signed [PX_W-1:0] map_px;
  logic signed [PY_W-1:0] map_py;
  logic signed [PX_W-1:0] cur_px;
  logic signed [PY_W-1:0] cur_py;
  logic signed [R_W:0]   half_w;
  logic                  span_last;
  logic                  active;
  logic                  cur_in;
  logic                  advance;

  logic signed [R_W:0]   oy_inc;
  logic signed [R_W:0]   ox_new;
  logic signed [R_W+1:0] diff;
  logic signed [R_W+1:0] crit_new;
  logic                  crit_le0;

  // A span row's left end is the octant point at (cx - halfwidth, row y):
  // rows cy+oy, cy-oy, cy+ox, cy-ox use octants 2, 4, 3, 5.
  always_comb begin
    k_sel = k_q;
    if (state == SPAN) begin
      case (row_q)
        2'd0:    k_sel = 3'd2;
        2'd1:    k_sel = 3'd4;
        2'd2:    k_sel = 3'd3;
        default: k_sel = 3'd5;
      endcase
    end
  end

  octant_mapper #(
    .X_W  (X_W),
    .Y_W  (Y_W),
    .R_W  (R_W),
    .PX_W (PX_W),
    .PY_W (PY_W)
  ) u_mapper (
    .cx (cx_q),
    .cy (cy_q),
    .ox (ox_q),
    .oy (oy_q),
    .k  (k_sel),
    .px (map_px),
    .py (map_py)
  );

  // Current pixel, clip test and handshake decode.
  always_comb begin
    half_w    = row_q[1] ? oy_q : ox_q;
    span_last = (j_q == {half_w, 1'b0});
    cur_px    = (state == SPAN) ? (map_px + PX_W'(j_q)) : map_px;
    cur_py    = map_py;
    active    = (state == PLOT) || (state == SPAN);
    cur_in    = clip_f(int'(cur_px), int'(cur_py), SCREEN_W, SCREEN_H);
    advance   = !cur_in || vga_ready;
    vga_plot  = active && cur_in;
    vga_x     = cur_px[X_W-1:0];
    vga_y     = cur_py[Y_W-1:0];
    vga_colour = colour_q;
    done      = (state == DONE);
  end

  // Midpoint decision update: oy steps first, ox possibly steps, then crit
  // uses the updated values.
  always_comb begin
    oy_inc   = oy_q + (R_W+1)'(1);
    crit_le0 = crit_q[R_W+1] || (crit_q == '0);
    ox_new   = crit_le0 ? ox_q : (ox_q - (R_W+1)'(1));
    diff     = crit_le0 ? (R_W+2)'(oy_inc) : ((R_W+2)'(oy_inc) - (R_W+2)'(ox_new));
    crit_new = crit_q + (diff <<< 1) + (R_W+2)'(1);
  end

  // Engine FSM and walk registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cx_q     <= '0;
      cy_q     <= '0;
      colour_q <= '0;
      fill_q   <= 1'b0;
      ox_q     <= '0;
      oy_q     <= '0;
      crit_q   <= '0;
      k_q      <= '0;
      row_q    <= '0;
      j_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cx_q     <= centre_x;
            cy_q     <= centre_y;
            colour_q <= colour;
            fill_q   <= fill;
            oy_q     <= '0;
            ox_q     <= (R_W+1)'(radius);
            crit_q   <= (R_W+2)'(1) - (R_W+2)'(radius);
            k_q      <= '0;
            row_q    <= '0;
            j_q      <= '0;
            state    <= fill ? SPAN : PLOT;
          end
        end
        PLOT: begin
          if (advance) begin
            if (k_q == 3'd7) begin
              k_q   <= '0;
              state <= STEP;
            end else begin
              k_q <= k_q + 3'd1;
            end
          end
        end
        SPAN: begin
          if (advance) begin
            if (span_last) begin
              j_q <= '0;
              if (row_q == 2'd3) begin
                row_q <= '0;
                state <= STEP;
              end else begin
                row_q <= row_q + 2'd1;
              end
            end else begin
              j_q <= j_q + (R_W+2)'(1);
            end
          end
        end
        STEP: begin
          oy_q   <= oy_inc;
          ox_q   <= ox_new;
          crit_q <= crit_new;
          if (oy_inc <= ox_new) state <= fill_q ? SPAN : PLOT;
          else                  state <= DONE;
        end
        DONE: begin
          if (!start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_circle_raster_engine.sv
// Directed bench for circle_raster_engine: outline, fill, clipping,
// back-pressure, done handshake and mid-draw reset.
module tb_circle_raster_engine;

  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int R_W = 8;
  localparam int C_W = 3;
  localparam int P_W = X_W + Y_W;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [X_W-1:0] centre_x;
  logic [Y_W-1:0] centre_y;
  logic [R_W-1:0] radius;
  logic [C_W-1:0] colour;
  logic           fill;
  logic           done;
  logic [X_W-1:0] vga_x;
  logic [Y_W-1:0] vga_y;
  logic [C_W-1:0] vga_colour;
  logic           vga_plot;
  logic           vga_ready;

  int checks = 0;
  int errors = 0;
  logic [P_W-1:0] exp_q[$];
  logic [P_W-1:0] got_q[$];

  circle_raster_engine dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .centre_x   (centre_x),
    .centre_y   (centre_y),
    .radius     (radius),
    .colour     (colour),
    .fill       (fill),
    .done       (done),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .vga_ready  (vga_ready)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected-value helpers.
  task automatic push_pt(input int x, input int y);
    exp_q.push_back({X_W'(x), Y_W'(y)});
  endtask

  task automatic push_row(input int y, input int xl, input int xr);
    for (int x = xl; x <= xr; x++) push_pt(x, y);
  endtask

  // Golden midpoint outline: octant order, clipped to 160x120.
  task automatic model_outline(input int cx, input int cy, input int r);
    int ox, oy, crit;
    int px[8];
    int py[8];
    exp_q.delete();
    ox = r; oy = 0; crit = 1 - r;
    while (oy <= ox) begin
      px = '{cx+ox, cx+oy, cx-ox, cx-oy, cx-ox, cx-oy, cx+ox, cx+oy};
      py = '{cy+oy, cy+ox, cy+oy, cy+ox, cy-oy, cy-ox, cy-oy, cy-ox};
      for (int k = 0; k < 8; k++)
        if (px[k] >= 0 && px[k] < 160 && py[k] >= 0 && py[k] < 120) push_pt(px[k], py[k]);
      oy++;
      if (crit <= 0) crit += 2*oy + 1;
      else begin
        ox--;
        crit += 2*(oy - ox) + 1;
      end
    end
  endtask

  // Driver: start a draw, collect accepted pixels, check stability under
  // stall, clipping and colour, then the done handshake. Inputs are
  // scrambled and start is toggled after the latch edge.
  task automatic run_draw(input int cx, input int cy, input int r, input int col,
                          input bit f, input bit rnd);
    bit hold = 1'b0;
    bit seen_done = 1'b0;
    logic [X_W-1:0] hx = '0;
    logic [Y_W-1:0] hy = '0;
    got_q.delete();
    @(negedge clk);
    centre_x = X_W'(cx); centre_y = Y_W'(cy); radius = R_W'(r);
    colour = C_W'(col); fill = f; vga_ready = 1'b1; start = 1'b1;
    for (int cyc = 0; cyc < 8000; cyc++) begin
      @(negedge clk);
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      if (cyc == 0) begin
        centre_x = '0; centre_y = '0; radius = 8'd3; colour = ~C_W'(col); fill = ~f;
      end
      if (cyc == 1) start = 1'b0;
      if (cyc == 2) start = 1'b1;
      if (hold) begin
        checks++;
        if (vga_plot !== 1'b1 || vga_x !== hx || vga_y !== hy) begin
          errors++;
          $display("FAIL hold_stable: got plot=%0b x=%0d y=%0d, want plot=1 x=%0d y=%0d",
                   vga_plot, vga_x, vga_y, hx, hy);
        end
      end
      if (vga_plot) begin
        checks++;
        if (vga_x >= 8'd160 || vga_y >= 7'd120 || vga_colour !== C_W'(col)) begin
          errors++;
          $display("FAIL plot_bounds: got x=%0d y=%0d colour=%0d, want x<160 y<120 colour=%0d",
                   vga_x, vga_y, vga_colour, col);
        end
      end
      vga_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (vga_plot && vga_ready) got_q.push_back({vga_x, vga_y});
      hold = vga_plot && !vga_ready;
      hx = vga_x;
      hy = vga_y;
    end
    checks++;
    if (!seen_done) begin
      errors++;
      $display("FAIL draw_timeout: done not seen, want done=1 within 8000 cycles");
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || vga_plot !== 1'b0) begin
      errors++;
      $display("FAIL done_hold: got done=%0b plot=%0b, want done=1 plot=0", done, vga_plot);
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_drop: got done=%0b, want 0", done);
    end
    vga_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; centre_x = '0; centre_y = '0; radius = '0;
    colour = '0; fill = 1'b0; vga_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b0 || vga_plot !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got done=%0b plot=%0b, want 0 0", done, vga_plot);
    end
    checks++;
    if (vga_x !== '0 || vga_y !== '0 || vga_colour !== '0) begin
      errors++;
      $display("FAIL reset_pixel: got x=%0d y=%0d c=%0d, want 0 0 0", vga_x, vga_y, vga_colour);
    end
    rst = 1'b0;
  endtask

  task automatic test_outline_r0();
    exp_q.delete();
    repeat (8) push_pt(80, 60);
    run_draw(80, 60, 0, 5, 1'b0, 1'b0);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL r0_count: got %0d plots, want %0d", got_q.size(), exp_q.size());
    end else
      for (int i = 0; i < exp_q.size(); i++)
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL r0_seq[%0d]: got (%0d,%0d) want (%0d,%0d)", i,
                   got_q[i][P_W-1:Y_W], got_q[i][Y_W-1:0], exp_q[i][P_W-1:Y_W], exp_q[i][Y_W-1:0]);
          break;
        end
  endtask

  task automatic test_outline_r1();
    exp_q.delete();
    push_pt(81,60); push_pt(80,61); push_pt(79,60); push_pt(80,61);
    push_pt(79,60); push_pt(80,59); push_pt(81,60); push_pt(80,59);
    push_pt(81,61); push_pt(81,61); push_pt(79,61); push_pt(79,61);
    push_pt(79,59); push_pt(79,59); push_pt(81,59); push_pt(81,59);
    run_draw(80, 60, 1, 7, 1'b0, 1'b0);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL r1_count: got %0d plots, want %0d", got_q.size(), exp_q.size());
    end else
      for (int i = 0; i < exp_q.size(); i++)
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL r1_seq[%0d]: got (%0d,%0d) want (%0d,%0d)", i,
                   got_q[i][P_W-1:Y_W], got_q[i][Y_W-1:0], exp_q[i][P_W-1:Y_W], exp_q[i][Y_W-1:0]);
          break;
        end
  endtask

  task automatic test_outline_r40(input bit rnd);
    model_outline(80, 60, 40);
    run_draw(80, 60, 40, 2, 1'b0, rnd);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL r40_count(rnd=%0b): got %0d plots, want %0d", rnd, got_q.size(), exp_q.size());
    end else
      for (int i = 0; i < exp_q.size(); i++)
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL r40_seq[%0d](rnd=%0b): got (%0d,%0d) want (%0d,%0d)", i, rnd,
                   got_q[i][P_W-1:Y_W], got_q[i][Y_W-1:0], exp_q[i][P_W-1:Y_W], exp_q[i][Y_W-1:0]);
          break;
        end
  endtask

  task automatic test_clip();
    model_outline(10, 5, 40);
    run_draw(10, 5, 40, 4, 1'b0, 1'b0);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL clip_count: got %0d plots, want %0d", got_q.size(), exp_q.size());
    end else
      for (int i = 0; i < exp_q.size(); i++)
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL clip_seq[%0d]: got (%0d,%0d) want (%0d,%0d)", i,
                   got_q[i][P_W-1:Y_W], got_q[i][Y_W-1:0], exp_q[i][P_W-1:Y_W], exp_q[i][Y_W-1:0]);
          break;
        end
  endtask

  task automatic model_fill_r2();
    exp_q.delete();
    push_row(60, 78, 82); push_row(60, 78, 82); push_row(62, 80, 80); push_row(58, 80, 80);
    push_row(61, 78, 82); push_row(59, 78, 82); push_row(62, 79, 81); push_row(58, 79, 81);
  endtask

  task automatic test_fill_r2();
    model_fill_r2();
    run_draw(80, 60, 2, 6, 1'b1, 1'b0);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL fill_count: got %0d plots, want %0d", got_q.size(), exp_q.size());
    end else
      for (int i = 0; i < exp_q.size(); i++)
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL fill_seq[%0d]: got (%0d,%0d) want (%0d,%0d)", i,
                   got_q[i][P_W-1:Y_W], got_q[i][Y_W-1:0], exp_q[i][P_W-1:Y_W], exp_q[i][Y_W-1:0]);
          break;
        end
  endtask

  // start held for a single cycle: done must pulse for exactly one cycle.
  task automatic test_done_pulse();
    int n_done = 0;
    int n_plot = 0;
    @(negedge clk);
    centre_x = 8'd80; centre_y = 7'd60; radius = '0; colour = 3'd1; fill = 1'b0;
    vga_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (done) n_done++;
      if (vga_plot) n_plot++;
      @(negedge clk);
    end
    checks++;
    if (n_done != 1) begin
      errors++;
      $display("FAIL done_pulse: got %0d done cycles, want 1", n_done);
    end
    checks++;
    if (n_plot != 8) begin
      errors++;
      $display("FAIL pulse_plots: got %0d plots, want 8", n_plot);
    end
  endtask

  task automatic test_fill_reset();
    @(negedge clk);
    centre_x = 8'd80; centre_y = 7'd60; radius = 8'd10; colour = 3'd3; fill = 1'b1;
    vga_ready = 1'b1; start = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (vga_plot !== 1'b1) begin
      errors++;
      $display("FAIL span_active: got plot=%0b, want 1 before reset", vga_plot);
    end
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    checks++;
    if (vga_plot !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL span_reset: got plot=%0b done=%0b, want 0 0", vga_plot, done);
    end
    rst = 1'b0;
    model_fill_r2();
    run_draw(80, 60, 2, 6, 1'b1, 1'b0);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL redraw_count: got %0d plots, want %0d", got_q.size(), exp_q.size());
    end else
      for (int i = 0; i < exp_q.size(); i++)
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL redraw_seq[%0d]: got (%0d,%0d) want (%0d,%0d)", i,
                   got_q[i][P_W-1:Y_W], got_q[i][Y_W-1:0], exp_q[i][P_W-1:Y_W], exp_q[i][Y_W-1:0]);
          break;
        end
  endtask

  // Test sequence and final report.
  initial begin
    test_reset();
    test_outline_r0();
    test_outline_r1();
    test_outline_r40(1'b0);
    test_clip();
    test_outline_r40(1'b1);
    test_fill_r2();
    test_done_pulse();
    test_fill_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
